// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Drives enable/direction of an external up/down counter so that its value
// walks to a commanded target, dwells there for DWELL cycles, then pulses done.
// Optional macro COUNTER_SEQ_PINGPONG_EN adds a RETURN leg back to the origin.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   command strobe, sampled only while idle
//   target     in   destination value, captured on accepted start
//   abort      in   cancels the current command from any state
//   sum        in   live counter value fed back from the counter
//   counter_en out  counter enable (combinational, stops exactly on target)
//   add_or_sub out  counter direction, 1 = up, 0 = down (registered)
//   busy       out  high while a command is in progress (registered)
//   done       out  one-cycle completion pulse (registered)
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             abort,
  input  logic [WIDTH-1:0] sum,
  output logic             counter_en,
  output logic             add_or_sub,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DWELL_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
`ifdef COUNTER_SEQ_PINGPONG_EN
    S_HOLD   = 2'd2,
    S_RETURN = 2'd3
`else
    S_HOLD   = 2'd2
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     tgt_q, tgt_d;
  logic                 dir_q, dir_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 busy_q, done_q, done_d;
`ifdef COUNTER_SEQ_PINGPONG_EN
  logic [WIDTH-1:0]     origin_q, origin_d;
`endif

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      dir_q    <= 1'b1;
      dwell_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef COUNTER_SEQ_PINGPONG_EN
      origin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      dir_q    <= dir_d;
      dwell_q  <= dwell_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
`ifdef COUNTER_SEQ_PINGPONG_EN
      origin_q <= origin_d;
`endif
    end
  end

  // Next-state, next-register values and the combinational counter enable
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    dir_d      = dir_q;
    dwell_d    = dwell_q;
    done_d     = 1'b0;
    counter_en = 1'b0;
`ifdef COUNTER_SEQ_PINGPONG_EN
    origin_d   = origin_q;
`endif
    if (abort) begin
      // Abort beats everything, including a simultaneous start in idle
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tgt_d = target;
`ifdef COUNTER_SEQ_PINGPONG_EN
            origin_d = sum;
`endif
            // Magnitude compare so the counter never wraps; equal keeps direction
            if (target > sum) begin
              dir_d = 1'b1;
            end else if (target < sum) begin
              dir_d = 1'b0;
            end
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          counter_en = (sum != tgt_q);
          if (sum == tgt_q) begin
            dwell_d = DWELL_W'(DWELL);
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          dwell_d = dwell_q - DWELL_W'(1);
          if (dwell_q == DWELL_W'(1)) begin
`ifdef COUNTER_SEQ_PINGPONG_EN
            dir_d   = ~dir_q;
            state_d = S_RETURN;
`else
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end
        end
`ifdef COUNTER_SEQ_PINGPONG_EN
        S_RETURN: begin
          counter_en = (sum != origin_q);
          if (sum == origin_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign add_or_sub = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int DWELL = 2;
`ifdef COUNTER_SEQ_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] target;
  logic       abort;
  logic [3:0] sum;
  logic       counter_en;
  logic       add_or_sub;
  logic       busy;
  logic       done;

  logic       load_en;
  logic [3:0] load_val;
  logic       freeze;

  int checks = 0;
  int failures = 0;
  logic exp_dir;

  counter_seq_ctrl #(.WIDTH(4), .DWELL(DWELL)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .target     (target),
    .abort      (abort),
    .sum        (sum),
    .counter_en (counter_en),
    .add_or_sub (add_or_sub),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // 4-bit up/down counter the sequencer steers; load and freeze are bench hooks
  always @(posedge clock) begin
    if (load_en) sum <= load_val;
    else if (counter_en === 1'b1 && !freeze) sum <= (add_or_sub ? sum + 4'd1 : sum - 4'd1);
  end

  task automatic set_sum(input logic [3:0] v);
    @(negedge clock);
    load_en = 1'b1;
    load_val = v;
    @(posedge clock);
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1'b1; start = 1'b0; abort = 1'b0; target = 4'd0; freeze = 1'b0;
    load_en = 1'b1; load_val = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    load_en = 1'b0;
    checks++;
    if ({counter_en, add_or_sub, busy, done} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_outputs: en/dir/busy/done got %b expected 0100", {counter_en, add_or_sub, busy, done});
    end
    checks++;
    if (sum !== 4'd0) begin
      failures++;
      $display("FAIL reset_sum: got %0d expected 0", sum);
    end
    reset = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (counter_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_quiet: activity seen with start low, expected none");
    end
    exp_dir = 1'b1;
  endtask

  // One command from s to t, with an optional extra start pulse while busy
  task automatic run_cmd(input logic [3:0] s, input logic [3:0] t, input int extra_c, input logic [3:0] extra_t);
    int n, en_cnt, done_edge, exp_en, exp_done;
    logic out_dir, want;
    bit dir_ok, tail_ok;
    set_sum(s);
    n = (t > s) ? int'(t - s) : int'(s - t);
    out_dir = (t > s) ? 1'b1 : ((t < s) ? 1'b0 : exp_dir);
    exp_en = PP ? 2 * n : n;
    exp_done = PP ? 2 * n + 2 + DWELL : n + 1 + DWELL;
    start = 1'b1;
    target = t;
    @(posedge clock);
    en_cnt = 0;
    done_edge = -1;
    dir_ok = 1'b1;
    for (int c = 1; c <= 100 && done_edge < 0; c++) begin
      @(negedge clock);
      start = (c == extra_c);
      target = (c == extra_c) ? extra_t : t;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_rise %0d->%0d: got %b expected 1", s, t, busy);
        end
      end
      if (counter_en === 1'b1) begin
        want = (en_cnt < n) ? out_dir : ~out_dir;
        if (add_or_sub !== want) dir_ok = 1'b0;
        en_cnt++;
      end
      if (done === 1'b1) begin
        done_edge = c - 1;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_fall %0d->%0d: got %b expected 0 with done", s, t, busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done_edge != exp_done) begin
      failures++;
      $display("FAIL done_edge %0d->%0d: got E%0d expected E%0d", s, t, done_edge, exp_done);
    end
    checks++;
    if (en_cnt != exp_en) begin
      failures++;
      $display("FAIL enable_cycles %0d->%0d: got %0d expected %0d", s, t, en_cnt, exp_en);
    end
    checks++;
    if (!dir_ok) begin
      failures++;
      $display("FAIL direction %0d->%0d: add_or_sub wrong while enabled, expected out=%b", s, t, out_dir);
    end
    exp_dir = PP ? ~out_dir : out_dir;
    tail_ok = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0 || counter_en !== 1'b0) tail_ok = 1'b0;
    end
    checks++;
    if (!tail_ok) begin
      failures++;
      $display("FAIL after_done %0d->%0d: extra activity after done, expected idle", s, t);
    end
    checks++;
    if (sum !== (PP ? s : t) || add_or_sub !== exp_dir) begin
      failures++;
      $display("FAIL final %0d->%0d: sum=%0d dir=%b expected sum=%0d dir=%b", s, t, sum, add_or_sub, PP ? s : t, exp_dir);
    end
  endtask

  task automatic test_directed();
    run_cmd(4'd3, 4'd9, 0, 4'd0);
    run_cmd(4'd12, 4'd2, 0, 4'd0);
    run_cmd(4'd5, 4'd5, 2, 4'd10);
    run_cmd(4'd4, 4'd7, 0, 4'd0);
  endtask

  task automatic test_random();
    logic [3:0] s, t;
    for (int i = 0; i < 16; i++) begin
      s = 4'($urandom_range(0, 15));
      t = 4'($urandom_range(0, 15));
      run_cmd(s, t, 0, 4'd0);
    end
  endtask

  task automatic test_abort();
    bit bad;
    set_sum(4'd0);
    start = 1'b1;
    target = 4'd15;
    @(posedge clock);
    repeat (3) begin
      @(negedge clock);
      start = 1'b0;
    end
    @(negedge clock);
    abort = 1'b1;
    #1;
    checks++;
    if (counter_en !== 1'b0 || sum !== 4'd3) begin
      failures++;
      $display("FAIL abort_same_cycle: en=%b sum=%0d expected en=0 sum=3", counter_en, sum);
    end
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: got %b expected 0", busy);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (done !== 1'b0 || counter_en !== 1'b0 || sum !== 4'd3) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_quiet: done/enable/sum change after abort, expected none (sum=%0d)", sum);
    end
    exp_dir = 1'b1;
  endtask

  task automatic test_abort_start_idle();
    bit bad;
    set_sum(4'd8);
    start = 1'b1;
    abort = 1'b1;
    target = 4'd2;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      if (busy !== 1'b0 || counter_en !== 1'b0 || add_or_sub !== exp_dir || sum !== 4'd8) bad = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_start_idle: busy=%b en=%b dir=%b sum=%0d expected 0 0 %b 8", busy, counter_en, add_or_sub, sum, exp_dir);
    end
  endtask

  task automatic test_stall();
    bit bad;
    set_sum(4'd1);
    start = 1'b1;
    target = 4'd6;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    freeze = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (busy !== 1'b1 || done !== 1'b0 || counter_en !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_run: left RUN with frozen sum %0d, expected to stay busy", sum);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    freeze = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL stall_abort: busy=%b done=%b expected 0 0", busy, done);
    end
    exp_dir = 1'b1;
  endtask

  task automatic test_reset_mid();
    set_sum(4'd2);
    start = 1'b1;
    target = 4'd12;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (counter_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_run: en=%b busy=%b expected 1 1", counter_en, busy);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({counter_en, add_or_sub, busy, done} !== 4'b0100) begin
      failures++;
      $display("FAIL async_reset: en/dir/busy/done got %b expected 0100", {counter_en, add_or_sub, busy, done});
    end
    @(negedge clock);
    reset = 1'b0;
    exp_dir = 1'b1;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, got1, got2, n2;
    logic [3:0] s2;
    set_sum(4'd1);
    lat1 = PP ? 2 * 2 + 2 + DWELL : 2 + 1 + DWELL;
    s2 = PP ? 4'd1 : 4'd3;
    n2 = int'(s2);
    lat2 = PP ? 2 * n2 + 2 + DWELL : n2 + 1 + DWELL;
    start = 1'b1;
    target = 4'd3;
    @(posedge clock);
    got1 = -1;
    for (int c = 1; c <= 100 && got1 < 0; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done === 1'b1) begin
        got1 = c - 1;
        start = 1'b1;
        target = 4'd0;
      end
    end
    @(posedge clock);
    got2 = -1;
    for (int c = 1; c <= 100 && got2 < 0; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_accept: busy got %b expected 1", busy);
        end
      end
      if (done === 1'b1) got2 = c - 1;
    end
    checks++;
    if (got1 != lat1 || got2 != lat2) begin
      failures++;
      $display("FAIL b2b_latency: got E%0d/E%0d expected E%0d/E%0d", got1, got2, lat1, lat2);
    end
    checks++;
    if (sum !== (PP ? s2 : 4'd0)) begin
      failures++;
      $display("FAIL b2b_sum: got %0d expected %0d", sum, PP ? s2 : 4'd0);
    end
    exp_dir = PP ? 1'b1 : 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_abort_start_idle();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
